// File: rtl/alu_issue_stage_pkg.sv
// Shared definitions for the ALU operand-issue stage: sizes, ALU mode codes
// and small helpers used by the top and its register file.
package alu_issue_stage_pkg;

  localparam int XLEN    = 32;
  localparam int NREGS   = 32;
  localparam int RADDR_W = 5;

  typedef enum logic [3:0] {
    MODE_ADD = 4'b0000,
    MODE_SUB = 4'b0001,
    MODE_AND = 4'b0010,
    MODE_OR  = 4'b0011,
    MODE_XOR = 4'b0100,
    MODE_NOT = 4'b0101,
    MODE_SLL = 4'b0110,
    MODE_SLA = 4'b0111,
    MODE_SRL = 4'b1000,
    MODE_SRA = 4'b1001
  } alu_mode_e;

  localparam logic [3:0] MODE_MAX = MODE_SRA;

  // Shift modes take only a 5-bit shift amount as operand2.
  function automatic logic is_shift(input logic [3:0] mode);
    return (mode >= MODE_SLL) && (mode <= MODE_MAX);
  endfunction

  function automatic logic is_illegal(input logic [3:0] mode);
    return mode > MODE_MAX;
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundle of the issue stage's instruction input, ALU-side output and
// write-back signals. slave = issue stage view, master = environment view.
interface alu_issue_stage_if
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int RADDR_W_P = RADDR_W
);
  logic                 in_valid;
  logic                 in_ready;
  logic [RADDR_W_P-1:0] in_rs;
  logic [RADDR_W_P-1:0] in_rt;
  logic [XLEN_P-1:0]    in_imm;
  logic                 in_use_imm;
  logic [3:0]           in_mode;
  logic [RADDR_W_P-1:0] in_rd;
  logic                 in_wr_en;

  logic [XLEN_P-1:0]    alu_operand1;
  logic [XLEN_P-1:0]    alu_operand2;
  logic [3:0]           alu_mode;
  logic                 alu_en;
  logic                 out_valid;
  logic                 out_ready;
  logic [RADDR_W_P-1:0] out_rd;
  logic                 out_wr_en;
  logic                 out_illegal;

  logic                 wb_en;
  logic [RADDR_W_P-1:0] wb_addr;
  logic [XLEN_P-1:0]    wb_data;

  modport slave (
    input  in_valid, in_rs, in_rt, in_imm, in_use_imm, in_mode, in_rd, in_wr_en,
    output in_ready,
    output alu_operand1, alu_operand2, alu_mode, alu_en,
    output out_valid, out_rd, out_wr_en, out_illegal,
    input  out_ready,
    input  wb_en, wb_addr, wb_data
  );

  modport master (
    output in_valid, in_rs, in_rt, in_imm, in_use_imm, in_mode, in_rd, in_wr_en,
    input  in_ready,
    input  alu_operand1, alu_operand2, alu_mode, alu_en,
    input  out_valid, out_rd, out_wr_en, out_illegal,
    output out_ready,
    output wb_en, wb_addr, wb_data
  );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// Architectural register file: two combinational read ports with same-cycle
// write-back bypass, one write port, register 0 hard-wired to zero.
module issue_regfile
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NREGS_P   = NREGS,
  parameter int RADDR_W_P = RADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RADDR_W_P-1:0] ra_i,
  input  logic [RADDR_W_P-1:0] rb_i,
  output logic [XLEN_P-1:0]    rdata_a_o,
  output logic [XLEN_P-1:0]    rdata_b_o,
  input  logic                 we_i,
  input  logic [RADDR_W_P-1:0] waddr_i,
  input  logic [XLEN_P-1:0]    wdata_i
);

  logic [XLEN_P-1:0] regs_q [NREGS_P];

  function automatic logic [XLEN_P-1:0] rd_port(input logic [RADDR_W_P-1:0] a);
    if (a == '0)                    return '0;
    else if (we_i && waddr_i == a)  return wdata_i;
    else                            return regs_q[a];
  endfunction

  // Write-back port; address 0 is never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS_P; i++) regs_q[i] <= '0;
    end else if (we_i && waddr_i != '0) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Combinational reads with bypass of the write-back in flight.
  always_comb begin
    rdata_a_o = rd_port(ra_i);
    rdata_b_o = rd_port(rb_i);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Operand-issue stage in front of the ALU: register read with bypass,
// immediate/shift operand2 shaping, busy-bit hazard stall and a single-entry
// registered output slot with valid/ready handshake.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
#(
  parameter int XLEN_P    = XLEN,
  parameter int NREGS_P   = NREGS,
  parameter int RADDR_W_P = RADDR_W
) (
  input logic               clk,
  input logic               rst,
  alu_issue_stage_if.slave  bus
);

  logic [XLEN_P-1:0]    rdata_a, rdata_b, op2_sel, op2_fmt;
  logic [NREGS_P-1:0]   busy_q, busy_d;
  logic                 valid_q, valid_d, illegal_q, illegal_d, wr_en_q, wr_en_d;
  logic [XLEN_P-1:0]    op1_q, op1_d, op2_q, op2_d;
  logic [3:0]           mode_q, mode_d;
  logic [RADDR_W_P-1:0] rd_q, rd_d;
  logic                 stall, free, accept, wb_live, in_illegal;

  issue_regfile #(
    .XLEN_P(XLEN_P), .NREGS_P(NREGS_P), .RADDR_W_P(RADDR_W_P)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .ra_i      (bus.in_rs),
    .rb_i      (bus.in_rt),
    .rdata_a_o (rdata_a),
    .rdata_b_o (rdata_b),
    .we_i      (bus.wb_en),
    .waddr_i   (bus.wb_addr),
    .wdata_i   (bus.wb_data)
  );

  // A busy register stops being a hazard in the cycle its write-back arrives.
  function automatic logic hit(input logic [RADDR_W_P-1:0] r);
    return (r != '0) && busy_q[r] && !(bus.wb_en && bus.wb_addr == r);
  endfunction

  // Hazard detection, handshake and operand2 shaping.
  always_comb begin
    wb_live    = bus.wb_en && (bus.wb_addr != '0);
    in_illegal = is_illegal(bus.in_mode);
    stall      = hit(bus.in_rs) || (!bus.in_use_imm && hit(bus.in_rt)) ||
                 (bus.in_wr_en && hit(bus.in_rd));
    free       = !valid_q || bus.out_ready;
    accept     = bus.in_valid && !rst && free && !stall;
    op2_sel    = bus.in_use_imm ? bus.in_imm : rdata_b;
    op2_fmt    = is_shift(bus.in_mode) ? {{(XLEN_P-5){1'b0}}, op2_sel[4:0]} : op2_sel;
  end

  // Next state of scoreboard and output slot; busy set is applied after the
  // clear so an accept on the same register keeps it busy.
  always_comb begin
    busy_d    = busy_q;
    valid_d   = valid_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    mode_d    = mode_q;
    rd_d      = rd_q;
    wr_en_d   = wr_en_q;
    illegal_d = illegal_q;
    if (wb_live) busy_d[bus.wb_addr] = 1'b0;
    if (accept) begin
      valid_d   = 1'b1;
      op1_d     = rdata_a;
      op2_d     = op2_fmt;
      mode_d    = bus.in_mode;
      rd_d      = bus.in_rd;
      wr_en_d   = bus.in_wr_en;
      illegal_d = in_illegal;
      if (bus.in_wr_en && bus.in_rd != '0 && !in_illegal) busy_d[bus.in_rd] = 1'b1;
    end else if (bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset drops any in-flight bundle and all busy bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q    <= '0;
      valid_q   <= 1'b0;
      op1_q     <= '0;
      op2_q     <= '0;
      mode_q    <= '0;
      rd_q      <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      valid_q   <= valid_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      mode_q    <= mode_d;
      rd_q      <= rd_d;
      wr_en_q   <= wr_en_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready     = !rst && free && !stall;
  assign bus.out_valid    = valid_q;
  assign bus.alu_operand1 = op1_q;
  assign bus.alu_operand2 = op2_q;
  assign bus.alu_mode     = mode_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_wr_en    = wr_en_q;
  assign bus.out_illegal  = illegal_q;
  assign bus.alu_en       = valid_q && !illegal_q;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Operand-issue stage directly upstream of the KGP-RISC ALU.
- Accepts decoded instructions and reads the register file with write-back bypass.
- Selects a register or immediate second operand, stalls on register hazards via a busy-bit scoreboard, and presents a registered operand1/operand2/mode/en bundle to the ALU with a valid/ready handshake.
- Receives write-back from the downstream stage to update registers and clear busy bits.

Parameters:
- XLEN, 32, data width; matches the ALU operand width.
- NREGS, 32, number of architectural registers; register 0 reads as zero.
- RADDR_W, 5, register address width (log2 NREGS).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs  in  RADDR_W  source register for operand1.
- in_rt  in  RADDR_W  source register for operand2.
- in_imm  in  XLEN  immediate value.
- in_use_imm  in  1  1 = operand2 comes from in_imm; in_rt is ignored.
- in_mode  in  4  ALU mode code (0000 to 1001 legal).
- in_rd  in  RADDR_W  destination register.
- in_wr_en  in  1  instruction writes in_rd.
- alu_operand1  out  XLEN  to ALU operand1.
- alu_operand2  out  XLEN  to ALU operand2.
- alu_mode  out  4  to ALU mode.
- alu_en  out  1  out_valid AND NOT out_illegal.
- out_valid  out  1  issued bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- out_rd  out  RADDR_W  destination carried alongside the bundle.
- out_wr_en  out  1  write intent carried alongside the bundle.
- out_illegal  out  1  mode code was above 1001.
- wb_en  in  1  write-back strobe.
- wb_addr  in  RADDR_W  write-back register.
- wb_data  in  XLEN  write-back value.

Behaviour:
- Reset is asynchronous and active-high.
  - Clears all registers and all busy bits.
  - Clears out_valid, out_illegal, out_wr_en, alu_operand1, alu_operand2, alu_mode and out_rd to 0.
  - in_ready is 0 while rst is high.
  - Reset asserted mid-operation discards the in-flight bundle; no write-back is lost beyond that cycle.
- Register read is combinational.
  - Address 0 always reads 0.
  - If wb_en is set and wb_addr equals the read address (nonzero), wb_data is bypassed in the same cycle.
- Operand2 selection:
  - in_use_imm=1 gives in_imm.
  - For shift modes 0110 to 1001, operand2 is reduced to its low 5 bits, zero-extended, after selection.
- Hazard: define hit(r) = busy[r] AND NOT (wb_en AND wb_addr==r), with r != 0.
  - stall = hit(in_rs) OR (NOT in_use_imm AND hit(in_rt)) OR (in_wr_en AND hit(in_rd)).
- Output slot is a single entry: free = NOT out_valid OR out_ready.
  - in_ready = NOT rst AND free AND NOT stall.
- Accept, when in_valid AND in_ready:
  - The next edge loads the output slot and sets out_valid=1.
  - Latency is exactly 1 cycle from acceptance to ALU inputs.
  - If in_wr_en AND in_rd != 0, busy[in_rd] is set.
- Hold: while out_valid AND NOT out_ready, all out_* and alu_* outputs stay stable.
- Drain: out_valid AND out_ready with no accept clears out_valid next edge; the payload may be left unchanged.
- Back-to-back: drain and accept in the same cycle is allowed, giving full throughput.
- Write-back, when wb_en AND wb_addr != 0:
  - Writes the register and clears busy[wb_addr].
  - Writes to address 0 are ignored.
- Simultaneous busy clear (write-back) and busy set (accept) on the same register: set wins.
- Illegal mode (above 1001):
  - The instruction is accepted and out_illegal=1.
  - No busy bit is set.
  - alu_en=0 for that bundle.
- The ALU is combinational, so the downstream stage captures ALU out in the same cycle that out_ready is high.

Decomposition:
- Shared package holds:
  - ALU mode constants: ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOT=0101, SLL=0110, SLA=0111, SRL=1000, SRA=1001.
  - MODE_MAX=1001.
  - XLEN, NREGS and RADDR_W defaults.
- One sub-module, issue_regfile: NREGS x XLEN storage with two combinational read ports, one write port, write-back bypass and zero register.
- Scoreboard, hazard logic and output slot live in the top module.

Test Plan:
- Write-back r3=0x0000_0005 and r4=0x0000_0007, then issue ADD rs=3 rt=4 rd=5 -> next cycle alu_operand1=5, alu_operand2=7, alu_mode=0000, alu_en=1, busy[5]=1.
- Issue rd=5, then dependent rs=5 with no write-back -> in_ready=0 until wb_en with wb_addr=5, wb_data=0xC; in that cycle in_ready=1 and operand1=0xC is bypassed.
- Hold out_ready=0 for 3 cycles with a bundle pending -> in_ready=0 and outputs stable; release -> back-to-back accept on the same edge the slot drains.
- SLL with in_use_imm=1, in_imm=0x0000_0123 -> alu_operand2=0x03; mode 1100 -> out_illegal=1, alu_en=0, no busy bit set.
- rs=0 with write-back wb_addr=0, wb_data=0xFFFF_FFFF -> operand1 stays 0; simultaneous write-back and accept both on r6 -> busy[6]=1 afterwards.
- Assert rst while out_valid=1 and busy[7]=1 -> out_valid=0, busy cleared and in_ready=0 immediately; in_ready=1 one cycle after rst falls.
